// File: rtl/ram_responder_2432_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_responder_2432_if
// Purpose  : Bundles the CPU data-port signals and the 16-bit asynchronous
//            SRAM pin signals seen by ram_responder_2432.
// Signals  : i_daddr[23:0]   CPU byte address        (CPU -> responder)
//            i_dout[31:0]    CPU store data          (CPU -> responder)
//            i_ram_rd        CPU load request        (CPU -> responder)
//            i_ram_wr[3:0]   CPU store lane strobes  (CPU -> responder)
//            o_din[31:0]     load data               (responder -> CPU)
//            o_clk_en        CPU clock enable        (responder -> CPU)
//            o_sram_addr     SRAM halfword address   (responder -> SRAM)
//            o_sram_dq_out   SRAM write data         (responder -> SRAM)
//            o_sram_dq_oe    SRAM dq drive enable    (responder -> SRAM)
//            i_sram_dq_in    SRAM read data          (SRAM -> responder)
//            o_sram_*_n      SRAM strobes, active-low(responder -> SRAM)
// Modports : slave = responder side, master = CPU/SRAM side.
// Revision : 1.0 - initial release
// ============================================================================
interface ram_responder_2432_if #(
  parameter int SRAM_AW = 18
);
  logic [23:0]        i_daddr;
  logic [31:0]        i_dout;
  logic               i_ram_rd;
  logic [3:0]         i_ram_wr;
  logic [31:0]        o_din;
  logic               o_clk_en;
  logic [SRAM_AW-1:0] o_sram_addr;
  logic [15:0]        o_sram_dq_out;
  logic               o_sram_dq_oe;
  logic [15:0]        i_sram_dq_in;
  logic               o_sram_ce_n;
  logic               o_sram_oe_n;
  logic               o_sram_we_n;
  logic               o_sram_lb_n;
  logic               o_sram_ub_n;

  modport slave (
    input  i_daddr, i_dout, i_ram_rd, i_ram_wr, i_sram_dq_in,
    output o_din, o_clk_en, o_sram_addr, o_sram_dq_out, o_sram_dq_oe,
           o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n
  );

  modport master (
    output i_daddr, i_dout, i_ram_rd, i_ram_wr, i_sram_dq_in,
    input  o_din, o_clk_en, o_sram_addr, o_sram_dq_out, o_sram_dq_oe,
           o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n
  );
endinterface
`default_nettype wire

// File: rtl/ram_responder_2432.sv
`default_nettype none
// ============================================================================
// Module   : ram_responder_2432
// Purpose  : Data-memory responder for the cpu_2432 data port. Latches each
//            load/store, runs it on a 16-bit asynchronous SRAM as one or two
//            halfword phases and stalls the CPU through o_clk_en until done.
// Ports    : i_clk   clock
//            i_rstb  asynchronous active-low reset
//            bus     ram_responder_2432_if.slave (CPU data port + SRAM pins)
// Params   : SRAM_AW     SRAM halfword address width
//            WAIT_STATES extra strobe cycles per SRAM phase (0..15)
// Revision : 1.0 - initial release
// ============================================================================
module ram_responder_2432 #(
  parameter int SRAM_AW     = 18,
  parameter int WAIT_STATES = 1
) (
  input wire                  i_clk,
  input wire                  i_rstb,
  ram_responder_2432_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_LO = 2'd1,
    GAP    = 2'd2,
    ACC_HI = 2'd3
  } state_t;

  localparam logic [3:0] C_WAIT = 4'(WAIT_STATES);

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [SRAM_AW-2:0] word_q, word_d;
  logic [31:0]        data_q, data_d;
  logic [3:0]         lanes_q, lanes_d;
  logic               wr_q, wr_d;

  logic [31:0]        din_q, din_d;
  logic               clk_en_q, clk_en_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [15:0]        dq_out_q, dq_out_d;
  logic               dq_oe_q, dq_oe_d;
  logic               ce_n_q, ce_n_d;
  logic               oe_n_q, oe_n_d;
  logic               we_n_q, we_n_d;
  logic               lb_n_q, lb_n_d;
  logic               ub_n_q, ub_n_d;

  logic               req_w;
  logic               half_w;
  logic               unused_w;

  assign req_w    = bus.i_ram_rd | (|bus.i_ram_wr);
  // Address bits outside the SRAM window alias; byte offset is not needed.
  assign unused_w = ^{bus.i_daddr[23:SRAM_AW+1], bus.i_daddr[1:0]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    data_d   = data_q;
    lanes_d  = lanes_q;
    wr_d     = wr_q;
    din_d    = din_q;
    clk_en_d = clk_en_q;
    addr_d   = addr_q;
    dq_out_d = dq_out_q;
    dq_oe_d  = 1'b0;
    ce_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    we_n_d   = 1'b1;
    lb_n_d   = 1'b1;
    ub_n_d   = 1'b1;
    half_w   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_w) begin
          word_d   = bus.i_daddr[SRAM_AW:2];
          data_d   = bus.i_dout;
          lanes_d  = bus.i_ram_wr;
          // Any lane set makes this a write; a concurrent read is dropped.
          wr_d     = |bus.i_ram_wr;
          clk_en_d = 1'b0;
          cnt_d    = C_WAIT;
          state_d  = (wr_d && (bus.i_ram_wr[1:0] == 2'b00)) ? ACC_HI : ACC_LO;
        end
      end
      ACC_LO: begin
        if (cnt_q == 4'd0) begin
          if (!wr_q) din_d[15:0] = bus.i_sram_dq_in;
          if (!wr_q || (lanes_q[3:2] != 2'b00)) begin
            state_d = GAP;
          end else begin
            state_d  = IDLE;
            clk_en_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      GAP: begin
        state_d = ACC_HI;
        cnt_d   = C_WAIT;
      end
      ACC_HI: begin
        if (cnt_q == 4'd0) begin
          if (!wr_q) din_d[31:16] = bus.i_sram_dq_in;
          state_d  = IDLE;
          clk_en_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // SRAM pins are registered, so they are decoded from the state being entered.
    if ((state_d == ACC_LO) || (state_d == ACC_HI)) begin
      half_w = (state_d == ACC_HI);
      ce_n_d = 1'b0;
      addr_d = {word_d, half_w};
      if (wr_d) begin
        we_n_d   = 1'b0;
        dq_oe_d  = 1'b1;
        dq_out_d = half_w ? data_d[31:16] : data_d[15:0];
        lb_n_d   = ~(half_w ? lanes_d[2] : lanes_d[0]);
        ub_n_d   = ~(half_w ? lanes_d[3] : lanes_d[1]);
      end else begin
        oe_n_d = 1'b0;
        lb_n_d = 1'b0;
        ub_n_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      word_q   <= '0;
      data_q   <= 32'd0;
      lanes_q  <= 4'd0;
      wr_q     <= 1'b0;
      din_q    <= 32'd0;
      clk_en_q <= 1'b1;
      addr_q   <= '0;
      dq_out_q <= 16'd0;
      dq_oe_q  <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      lb_n_q   <= 1'b1;
      ub_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      data_q   <= data_d;
      lanes_q  <= lanes_d;
      wr_q     <= wr_d;
      din_q    <= din_d;
      clk_en_q <= clk_en_d;
      addr_q   <= addr_d;
      dq_out_q <= dq_out_d;
      dq_oe_q  <= dq_oe_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      lb_n_q   <= lb_n_d;
      ub_n_q   <= ub_n_d;
    end
  end

  assign bus.o_din         = din_q;
  assign bus.o_clk_en      = clk_en_q;
  assign bus.o_sram_addr   = addr_q;
  assign bus.o_sram_dq_out = dq_out_q;
  assign bus.o_sram_dq_oe  = dq_oe_q;
  assign bus.o_sram_ce_n   = ce_n_q;
  assign bus.o_sram_oe_n   = oe_n_q;
  assign bus.o_sram_we_n   = we_n_q;
  assign bus.o_sram_lb_n   = lb_n_q;
  assign bus.o_sram_ub_n   = ub_n_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_responder_2432.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_responder_2432
// Purpose  : Two responders (WAIT_STATES=1 and 0), each on its own SRAM model,
//            checked every cycle against a transaction-timeline model and by
//            hand-computed stall/data values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_responder_2432;

  localparam int AW = 18;

  typedef struct packed {
    logic          clk_en;
    logic          ce_n;
    logic          oe_n;
    logic          we_n;
    logic          lb_n;
    logic          ub_n;
    logic          dq_oe;
    logic [AW-1:0] addr;
    logic [15:0]   dq_out;
    logic [31:0]   din;
  } rec_t;

  logic clk  = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] daddr [2];
  logic [31:0] dout  [2];
  logic [1:0]  rdv;
  logic [3:0]  wrv   [2];

  logic [1:0]    clk_en_mon, ce_mon, we_mon, oe_mon, dqoe_mon;
  logic [31:0]   din_mon  [2];
  logic [AW-1:0] addr_mon [2];
  logic [15:0]   dqo_mon  [2];

  int total = 0;
  int bad   = 0;

  // Cycle with no access: strobes released, CPU running, load data held.
  function automatic rec_t idle_rec(input logic [31:0] din);
    rec_t r;
    r        = '0;
    r.clk_en = 1'b1;
    r.ce_n   = 1'b1;
    r.oe_n   = 1'b1;
    r.we_n   = 1'b1;
    r.lb_n   = 1'b1;
    r.ub_n   = 1'b1;
    r.din    = din;
    return r;
  endfunction

  // One strobe cycle of a halfword phase.
  function automatic rec_t phase_rec(input logic iswr, input logic [3:0] lanes, input logic h,
                                     input logic [AW-2:0] word, input logic [31:0] data,
                                     input logic [31:0] din);
    rec_t r;
    r        = idle_rec(din);
    r.clk_en = 1'b0;
    r.ce_n   = 1'b0;
    r.addr   = {word, h};
    if (iswr) begin
      r.we_n   = 1'b0;
      r.dq_oe  = 1'b1;
      r.dq_out = h ? data[31:16] : data[15:0];
      r.lb_n   = ~(h ? lanes[2] : lanes[0]);
      r.ub_n   = ~(h ? lanes[3] : lanes[1]);
    end else begin
      r.oe_n = 1'b0;
      r.lb_n = 1'b0;
      r.ub_n = 1'b0;
    end
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int W = (g == 0) ? 1 : 0;

    ram_responder_2432_if #(.SRAM_AW(AW)) bus ();
    bit [15:0]     mem [1 << AW];
    rec_t          cur, r;
    rec_t          tl [$];
    logic [31:0]   d;
    logic [AW-2:0] word;
    logic          iswr, dolo, dohi, ok;

    assign bus.i_daddr      = daddr[g];
    assign bus.i_dout       = dout[g];
    assign bus.i_ram_rd     = rdv[g];
    assign bus.i_ram_wr     = wrv[g];
    assign bus.i_sram_dq_in = (!bus.o_sram_ce_n && !bus.o_sram_oe_n) ? mem[bus.o_sram_addr] : 16'hA5A5;

    assign clk_en_mon[g] = bus.o_clk_en;
    assign ce_mon[g]     = bus.o_sram_ce_n;
    assign we_mon[g]     = bus.o_sram_we_n;
    assign oe_mon[g]     = bus.o_sram_oe_n;
    assign dqoe_mon[g]   = bus.o_sram_dq_oe;
    assign din_mon[g]    = bus.o_din;
    assign addr_mon[g]   = bus.o_sram_addr;
    assign dqo_mon[g]    = bus.o_sram_dq_out;

    ram_responder_2432 #(.SRAM_AW(AW), .WAIT_STATES(W)) dut (
      .i_clk  (clk),
      .i_rstb (rstb),
      .bus    (bus)
    );

    // SRAM array plus expected-output timeline for this responder.
    initial begin
      cur = idle_rec(32'd0);
      forever begin
        @(posedge clk or negedge rstb);
        if (!rstb) begin
          tl.delete();
          cur = idle_rec(32'd0);
        end else begin
          if (!bus.o_sram_ce_n && !bus.o_sram_we_n) begin
            if (!bus.o_sram_lb_n) mem[bus.o_sram_addr][7:0]  = bus.o_sram_dq_out[7:0];
            if (!bus.o_sram_ub_n) mem[bus.o_sram_addr][15:8] = bus.o_sram_dq_out[15:8];
          end
          if ((tl.size() == 0) && cur.clk_en && (rdv[g] || (|wrv[g]))) begin
            iswr = |wrv[g];
            dolo = !iswr || (wrv[g][1:0] != 2'b00);
            dohi = !iswr || (wrv[g][3:2] != 2'b00);
            word = daddr[g][AW:2];
            d    = cur.din;
            if (dolo) begin
              for (int i = 0; i <= W; i++) tl.push_back(phase_rec(iswr, wrv[g], 1'b0, word, dout[g], d));
              if (!iswr) d[15:0] = mem[{word, 1'b0}];
              if (dohi) begin
                r        = idle_rec(d);
                r.clk_en = 1'b0;
                tl.push_back(r);
              end
            end
            if (dohi) begin
              for (int i = 0; i <= W; i++) tl.push_back(phase_rec(iswr, wrv[g], 1'b1, word, dout[g], d));
              if (!iswr) d[31:16] = mem[{word, 1'b1}];
            end
            tl.push_back(idle_rec(d));
          end
          if (tl.size() > 0) cur = tl.pop_front();
          else cur = idle_rec(cur.din);
        end
      end
    end

    initial begin
      forever begin
        @(negedge clk);
        ok = (bus.o_clk_en === cur.clk_en) && (bus.o_sram_ce_n === cur.ce_n) &&
             (bus.o_sram_oe_n === cur.oe_n) && (bus.o_sram_we_n === cur.we_n) &&
             (bus.o_sram_lb_n === cur.lb_n) && (bus.o_sram_ub_n === cur.ub_n) &&
             (bus.o_sram_dq_oe === cur.dq_oe) && (bus.o_din === cur.din) &&
             (cur.ce_n || (bus.o_sram_addr === cur.addr)) &&
             (cur.we_n || (bus.o_sram_dq_out === cur.dq_out));
        total++;
        if (!ok) begin
          bad++;
          $display("FAIL cycle_g%0d t=%0t got en=%b ce=%b oe=%b we=%b lb=%b ub=%b dqoe=%b a=%h dq=%h din=%h want en=%b ce=%b oe=%b we=%b lb=%b ub=%b dqoe=%b a=%h dq=%h din=%h",
                   g, $time, bus.o_clk_en, bus.o_sram_ce_n, bus.o_sram_oe_n, bus.o_sram_we_n,
                   bus.o_sram_lb_n, bus.o_sram_ub_n, bus.o_sram_dq_oe, bus.o_sram_addr,
                   bus.o_sram_dq_out, bus.o_din, cur.clk_en, cur.ce_n, cur.oe_n, cur.we_n,
                   cur.lb_n, cur.ub_n, cur.dq_oe, cur.addr, cur.dq_out, cur.din);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input int n, input logic [23:0] a, input logic [31:0] wd,
                       input logic rd, input logic [3:0] wr);
    daddr[n] = a;
    dout[n]  = wd;
    rdv[n]   = rd;
    wrv[n]   = wr;
  endtask

  task automatic idle(input int n, input int cycles);
    drive(n, 24'd0, 32'd0, 1'b0, 4'd0);
    repeat (cycles) @(negedge clk);
  endtask

  // Presents one request and returns at the negedge of its completion cycle.
  task automatic access(input int n, input string tag, input logic [23:0] a, input logic [31:0] wd,
                        input logic rd, input logic [3:0] wr, input int exp_stall,
                        input logic chk_din, input logic [31:0] exp_din);
    int   stall;
    logic oe_seen;
    logic tmo;
    drive(n, a, wd, rd, wr);
    stall   = 0;
    oe_seen = 1'b0;
    tmo     = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!oe_mon[n]) oe_seen = 1'b1;
      if (!clk_en_mon[n]) stall++;
      else if (stall > 0) begin
        tmo = 1'b0;
        break;
      end
    end
    chk({tag, "_timeout"}, {31'd0, tmo}, 32'd0);
    chk({tag, "_stall"}, 32'(stall), 32'(exp_stall));
    chk({tag, "_oe_pulse"}, {31'd0, oe_seen}, {31'd0, (wr == 4'd0)});
    if (chk_din) chk({tag, "_din"}, din_mon[n], exp_din);
  endtask

  initial begin
    int stall;
    for (int n = 0; n < 2; n++) drive(n, 24'd0, 32'd0, 1'b0, 4'd0);
    repeat (3) @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("reset_clk_en_%0d", n), {31'd0, clk_en_mon[n]}, 32'd1);
      chk($sformatf("reset_din_%0d", n), din_mon[n], 32'd0);
      chk($sformatf("reset_addr_%0d", n), {14'd0, addr_mon[n]}, 32'd0);
      chk($sformatf("reset_dq_%0d", n), {16'd0, dqo_mon[n]}, 32'd0);
      chk($sformatf("reset_strobes_%0d", n), {28'd0, ce_mon[n], we_mon[n], oe_mon[n], dqoe_mon[n]}, 32'hE);
    end
    rstb = 1'b1;
    idle(0, 2);

    // WAIT_STATES = 1
    access(0, "sto_w",  24'h000020, 32'hDEADBEEF, 1'b0, 4'b1111, 5, 1'b0, 32'd0);
    idle(0, 2);
    access(0, "sto_b",  24'h000020, 32'h00AB0000, 1'b0, 4'b0100, 2, 1'b0, 32'd0);
    idle(0, 2);
    access(0, "ld_20",  24'h000020, 32'd0, 1'b1, 4'b0000, 5, 1'b1, 32'hDEABBEEF);
    idle(0, 2);
    access(0, "sto_10", 24'h000010, 32'h12345678, 1'b0, 4'b1111, 5, 1'b0, 32'd0);
    idle(0, 2);
    access(0, "ld_10",  24'h000010, 32'd0, 1'b1, 4'b0000, 5, 1'b1, 32'h12345678);
    idle(0, 2);
    access(0, "rd_wr",  24'h000010, 32'h000000EE, 1'b1, 4'b0001, 2, 1'b1, 32'h12345678);
    idle(0, 2);
    access(0, "ld_10b", 24'h000010, 32'd0, 1'b1, 4'b0000, 5, 1'b1, 32'h123456EE);
    idle(0, 2);
    access(0, "alias",  24'h800010, 32'd0, 1'b1, 4'b0000, 5, 1'b1, 32'h123456EE);
    idle(0, 2);

    // Reset lands in the first ACC_HI cycle of a two-phase store.
    drive(0, 24'h000030, 32'hCAFEF00D, 1'b0, 4'b1111);
    stall = 0;
    for (int i = 0; (i < 40) && (stall < 4); i++) begin
      @(negedge clk);
      if (!clk_en_mon[0]) stall++;
    end
    chk("arst_pre_stall", 32'(stall), 32'd4);
    chk("arst_pre_we", {31'd0, we_mon[0]}, 32'd0);
    #2 rstb = 1'b0;
    #1;
    chk("arst_clk_en", {31'd0, clk_en_mon[0]}, 32'd1);
    chk("arst_strobes", {29'd0, ce_mon[0], we_mon[0], dqoe_mon[0]}, 32'h6);
    chk("arst_din", din_mon[0], 32'd0);
    drive(0, 24'd0, 32'd0, 1'b0, 4'd0);
    @(negedge clk);
    @(negedge clk);
    rstb = 1'b1;
    idle(0, 2);
    access(0, "ld_30", 24'h000030, 32'd0, 1'b1, 4'b0000, 5, 1'b1, 32'h0000F00D);
    idle(0, 2);

    // WAIT_STATES = 0, back-to-back loads
    access(1, "w0_sto_a", 24'h000100, 32'h11112222, 1'b0, 4'b1111, 3, 1'b0, 32'd0);
    idle(1, 2);
    access(1, "w0_sto_b", 24'h000104, 32'h33334444, 1'b0, 4'b1111, 3, 1'b0, 32'd0);
    idle(1, 2);
    access(1, "w0_ld_a",  24'h000100, 32'd0, 1'b1, 4'b0000, 3, 1'b1, 32'h11112222);
    access(1, "w0_ld_b",  24'h000104, 32'd0, 1'b1, 4'b0000, 3, 1'b1, 32'h33334444);
    idle(1, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
